// File: rtl/ahb_slave_if_if.sv
// rtl/ahb_slave_if_if.sv - AHB-side bus bundle between the AHB master and the bridge front end
interface ahb_slave_if_if;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic        Hwritereg1;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Herr_ready;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
               tempselx, Hrdata, Hresp, Herr_ready
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
               tempselx, Hrdata, Hresp, Herr_ready
    );
endinterface

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB front end of the AHB-to-APB bridge; AHB_SLV_ERR_RESP_EN adds the out-of-range ERROR responder
module ahb_slave_if #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLOT_SIZE = 32'h0400_0000
) (
    input  logic          Hclk,
    input  logic          Hresetn,
    ahb_slave_if_if.slave bus
);
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HTRANS_SEQ    = 2'b11;
    localparam int unsigned SLOT_SHIFT    = $clog2(SLOT_SIZE);
    // Computed in 33 bits so a window reaching the top of the address map cannot wrap.
    localparam logic [32:0] WIN_SIZE      = {1'b0, SLOT_SIZE} * 33'd3;

    logic [31:0] addr_off;
    logic [31:0] slot_idx;
    logic        in_range;
    logic        xfer_active;

    always_comb begin
        addr_off     = bus.Haddr - BASE_ADDR;
        slot_idx     = addr_off >> SLOT_SHIFT;
        bus.tempselx = 3'b000;
        if ((bus.Haddr >= BASE_ADDR) && ({1'b0, addr_off} < WIN_SIZE)) begin
            case (slot_idx)
                32'd0:   bus.tempselx = 3'b001;
                32'd1:   bus.tempselx = 3'b010;
                32'd2:   bus.tempselx = 3'b100;
                default: bus.tempselx = 3'b000;
            endcase
        end
    end

    assign in_range    = |bus.tempselx;
    assign xfer_active = (bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ);
    assign bus.valid   = Hresetn & bus.Hreadyin & xfer_active & in_range;
    assign bus.Hrdata  = bus.Prdata;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            bus.Haddr1     <= 32'h0;
            bus.Haddr2     <= 32'h0;
            bus.Hwdata1    <= 32'h0;
            bus.Hwdata2    <= 32'h0;
            bus.Hwritereg  <= 1'b0;
            bus.Hwritereg1 <= 1'b0;
        end else if (bus.Hreadyin) begin
            bus.Haddr1     <= bus.Haddr;
            bus.Haddr2     <= bus.Haddr1;
            bus.Hwdata1    <= bus.Hwdata;
            bus.Hwdata2    <= bus.Hwdata1;
            bus.Hwritereg  <= bus.Hwrite;
            bus.Hwritereg1 <= bus.Hwritereg;
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    localparam logic [1:0] E_IDLE = 2'b00;
    localparam logic [1:0] E_ERR1 = 2'b01;
    localparam logic [1:0] E_ERR2 = 2'b10;

    logic [1:0] err_state;

    // Transfers arriving during E_ERR1/E_ERR2 are ignored; the master must answer ERROR with IDLE.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            err_state <= E_IDLE;
        end else begin
            case (err_state)
                E_IDLE:  if (bus.Hreadyin && xfer_active && !in_range) err_state <= E_ERR1;
                E_ERR1:  err_state <= E_ERR2;
                default: err_state <= E_IDLE;
            endcase
        end
    end

    assign bus.Hresp      = (err_state == E_IDLE) ? 2'b00 : 2'b01;
    assign bus.Herr_ready = (err_state != E_ERR1);
`else
    assign bus.Hresp      = 2'b00;
    assign bus.Herr_ready = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - scoreboard bench for ahb_slave_if with directed and randomized AHB traffic
module tb_ahb_slave_if;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SLOT = 32'h0400_0000;
    localparam logic [1:0]  IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    logic Hclk = 1'b0;
    logic Hresetn;
    always #5 Hclk = ~Hclk;

    ahb_slave_if_if bus ();

    ahb_slave_if #(.BASE_ADDR(BASE), .SLOT_SIZE(SLOT)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus.slave)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  sel;
        logic [31:0] a1, a2, w1, w2;
        logic        wr1, wr2;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        eready;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state: last two accepted transfers and remaining ERROR cycles.
    logic [31:0] m_addr[2];
    logic [31:0] m_wdat[2];
    logic        m_wr[2];
    int          m_err;

    logic        p_rst, p_wr, p_rdy;
    logic [1:0]  p_tr;
    logic [31:0] p_addr, p_wd;

    function automatic logic [2:0] dec(input logic [31:0] a);
        longint off;
        longint slot;
        slot = longint'({32'd0, SLOT});
        off  = longint'({32'd0, a}) - longint'({32'd0, BASE});
        if (off >= 0 && off < 3 * slot) return 3'(1 << int'(off / slot));
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_addr = '{32'h0, 32'h0};
        m_wdat = '{32'h0, 32'h0};
        m_wr   = '{1'b0, 1'b0};
        m_err  = 0;
    endtask

    task automatic model_clock();
        if (!p_rst) return;
        if (m_err > 0) m_err--;
`ifdef AHB_SLV_ERR_RESP_EN
        else if (p_rdy && p_tr[1] && dec(p_addr) == 3'b000) m_err = 2;
`endif
        if (p_rdy) begin
            m_addr[1] = m_addr[0]; m_addr[0] = p_addr;
            m_wdat[1] = m_wdat[0]; m_wdat[0] = p_wd;
            m_wr[1]   = m_wr[0];   m_wr[0]   = p_wr;
        end
    endtask

    task automatic cycle(input logic rst, input logic wr, input logic rdy, input logic [1:0] tr,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pd);
        exp_t e;
        @(posedge Hclk);
        model_clock();
        #1;
        Hresetn = rst; bus.Hwrite = wr; bus.Hreadyin = rdy; bus.Htrans = tr;
        bus.Haddr = addr; bus.Hwdata = wd; bus.Prdata = pd;
        p_rst = rst; p_wr = wr; p_rdy = rdy; p_tr = tr; p_addr = addr; p_wd = wd;
        if (!rst) model_reset();
        e.valid  = rst && rdy && tr[1] && (dec(addr) != 3'b000);
        e.sel    = dec(addr);
        e.a1     = m_addr[0]; e.a2 = m_addr[1];
        e.w1     = m_wdat[0]; e.w2 = m_wdat[1];
        e.wr1    = m_wr[0];   e.wr2 = m_wr[1];
        e.rdata  = pd;
        e.resp   = (m_err > 0) ? 2'b01 : 2'b00;
        e.eready = (m_err != 2);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid",      {31'd0, bus.valid},      {31'd0, e.valid});
                chk("tempselx",   {29'd0, bus.tempselx},   {29'd0, e.sel});
                chk("Haddr1",     bus.Haddr1,              e.a1);
                chk("Haddr2",     bus.Haddr2,              e.a2);
                chk("Hwdata1",    bus.Hwdata1,             e.w1);
                chk("Hwdata2",    bus.Hwdata2,             e.w2);
                chk("Hwritereg",  {31'd0, bus.Hwritereg},  {31'd0, e.wr1});
                chk("Hwritereg1", {31'd0, bus.Hwritereg1}, {31'd0, e.wr2});
                chk("Hrdata",     bus.Hrdata,              e.rdata);
                chk("Hresp",      {30'd0, bus.Hresp},      {30'd0, e.resp});
                chk("Herr_ready", {31'd0, bus.Herr_ready}, {31'd0, e.eready});
            end
        end
    end

    initial begin
        logic [31:0] sweep[5];
        logic [1:0]  trs[3];
        logic [31:0] a;
        sweep = '{32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
        trs   = '{NONSEQ, IDLE, BUSY};

        Hresetn = 1'b0; bus.Hwrite = 1'b0; bus.Hreadyin = 1'b0; bus.Htrans = IDLE;
        bus.Haddr = 32'h0; bus.Hwdata = 32'h0; bus.Prdata = 32'h0;
        p_rst = 1'b0; p_wr = 1'b0; p_rdy = 1'b0; p_tr = IDLE; p_addr = 32'h0; p_wd = 32'h0;
        model_reset();
        repeat (2) cycle(1'b0, 1'b0, 1'b1, IDLE, 32'h0, 32'h0, 32'h0);

        cycle(1'b1, 1'b1, 1'b1, NONSEQ, 32'h8000_0010, 32'h1234_5678, 32'h0);
        repeat (2) cycle(1'b1, 1'b0, 1'b1, IDLE, 32'h0, 32'h0, 32'h0);

        cycle(1'b1, 1'b1, 1'b1, NONSEQ, 32'h8000_0100, 32'hA5A5_0001, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, SEQ,    32'h8000_0104, 32'hA5A5_0002, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, NONSEQ, 32'h8000_0200, 32'hFFFF_FFFF, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, IDLE, 32'h0, 32'h0, 32'h0);

        for (int t = 0; t < 3; t++)
            for (int i = 0; i < 5; i++) begin
                cycle(1'b1, 1'b0, 1'b1, trs[t], sweep[i], 32'h0, 32'h0);
                repeat (2) cycle(1'b1, 1'b0, 1'b1, IDLE, 32'h0, 32'h0, 32'h0);
            end

        cycle(1'b1, 1'b0, 1'b1, NONSEQ, 32'h9000_0000, 32'h0, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 1'b1, IDLE, 32'h0, 32'h0, 32'h0);

        cycle(1'b1, 1'b0, 1'b1, NONSEQ, 32'h8400_0020, 32'h0, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b0, 1'b1, IDLE,   32'h0,         32'h0, 32'h0);

        cycle(1'b1, 1'b1, 1'b1, NONSEQ, 32'h8800_0040, 32'h5555_AAAA, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, NONSEQ, 32'hF000_0000, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, IDLE,   32'h0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, NONSEQ, 32'h8000_0000, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, IDLE,   32'h0, 32'h0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + $urandom_range(0, 32'h0BFF_FFFF);
                2:       a = BASE + 32'h0C00_0000 - 32'h8 + $urandom_range(0, 16);
                default: a = $urandom;
            endcase
            cycle($urandom_range(0, 39) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                  2'($urandom), a, $urandom, $urandom);
        end

        @(negedge Hclk);
        @(negedge Hclk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
